// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Free-running VGA/DVI raster timing generator. Emits registered,
//               mutually aligned hsync/vsync/blank/frame and beam position.
//               Optional RGB test pattern ports with VGA_TIMING_TEST_PATTERN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int c_resolution_x      = 640,
    parameter int c_hsync_front_porch = 16,
    parameter int c_hsync_pulse       = 96,
    parameter int c_hsync_back_porch  = 48,
    parameter int c_resolution_y      = 480,
    parameter int c_vsync_front_porch = 10,
    parameter int c_vsync_pulse       = 2,
    parameter int c_vsync_back_porch  = 33,
    parameter int c_bits_x            = 10,
    parameter int c_bits_y            = 10,
    parameter bit c_hsync_polarity    = 1'b0,
    parameter bit c_vsync_polarity    = 1'b0
) (
    input  logic                clk_pixel,
    input  logic                resetn,
    input  logic                clk_pixel_ena,
    output logic [c_bits_x-1:0] o_x,
    output logic [c_bits_y-1:0] o_y,
    output logic                o_hsync,
    output logic                o_vsync,
    output logic                o_blank,
    output logic                o_frame
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    output logic [7:0]          o_r,
    output logic [7:0]          o_g,
    output logic [7:0]          o_b
`endif
);

    localparam int c_h_total = c_resolution_x + c_hsync_front_porch
                             + c_hsync_pulse + c_hsync_back_porch;
    localparam int c_v_total = c_resolution_y + c_vsync_front_porch
                             + c_vsync_pulse + c_vsync_back_porch;

    localparam logic [c_bits_x-1:0] c_x_last   = c_bits_x'(c_h_total - 1);
    localparam logic [c_bits_x-1:0] c_x_active = c_bits_x'(c_resolution_x);
    localparam logic [c_bits_x-1:0] c_hs_first = c_bits_x'(c_resolution_x + c_hsync_front_porch);
    localparam logic [c_bits_x-1:0] c_hs_last  = c_bits_x'(c_resolution_x + c_hsync_front_porch
                                                          + c_hsync_pulse - 1);

    localparam logic [c_bits_y-1:0] c_y_last   = c_bits_y'(c_v_total - 1);
    localparam logic [c_bits_y-1:0] c_y_active = c_bits_y'(c_resolution_y);
    localparam logic [c_bits_y-1:0] c_vs_first = c_bits_y'(c_resolution_y + c_vsync_front_porch);
    localparam logic [c_bits_y-1:0] c_vs_last  = c_bits_y'(c_resolution_y + c_vsync_front_porch
                                                          + c_vsync_pulse - 1);

    logic [c_bits_x-1:0] r_cx;
    logic [c_bits_y-1:0] r_cy;

    logic [c_bits_x-1:0] r_x;
    logic [c_bits_y-1:0] r_y;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_blank;
    logic                r_frame;

    logic w_x_wrap;
    logic w_y_wrap;
    logic w_blank;
    logic w_hs_active;
    logic w_vs_active;
    logic w_frame;

    // ------------------------------------------------------------------
    // Beam counters: exact-compare wrap, y advances only on x wrap
    // ------------------------------------------------------------------
    assign w_x_wrap = (r_cx == c_x_last);
    assign w_y_wrap = (r_cy == c_y_last);

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (clk_pixel_ena) begin
            if (w_x_wrap) begin
                r_cx <= '0;
                if (w_y_wrap) begin
                    r_cy <= '0;
                end else begin
                    r_cy <= r_cy + 1'b1;
                end
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode of the current (pre-increment) counter values
    // ------------------------------------------------------------------
    assign w_blank     = (r_cx >= c_x_active) | (r_cy >= c_y_active);
    assign w_hs_active = (r_cx >= c_hs_first) & (r_cx <= c_hs_last);
    // vsync looks at cy only so its edges land on cx = 0
    assign w_vs_active = (r_cy >= c_vs_first) & (r_cy <= c_vs_last);
    assign w_frame     = (r_cx == '0) & (r_cy == '0);

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            r_x     <= '0;
            r_y     <= '0;
            r_hsync <= ~c_hsync_polarity;
            r_vsync <= ~c_vsync_polarity;
            r_blank <= 1'b1;
            r_frame <= 1'b0;
        end else if (clk_pixel_ena) begin
            r_x     <= r_cx;
            r_y     <= r_cy;
            r_hsync <= w_hs_active ? c_hsync_polarity : ~c_hsync_polarity;
            r_vsync <= w_vs_active ? c_vsync_polarity : ~c_vsync_polarity;
            r_blank <= w_blank;
            r_frame <= w_frame;
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_hsync = r_hsync;
    assign o_vsync = r_vsync;
    assign o_blank = r_blank;
    assign o_frame = r_frame;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int c_px_w = (c_bits_x < 8) ? c_bits_x : 8;
    localparam int c_py_w = (c_bits_y < 8) ? c_bits_y : 8;

    logic [7:0] w_cx_lo;
    logic [7:0] w_cy_lo;
    logic       w_cx4;
    logic       w_cy4;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;

    assign w_cx_lo = 8'(r_cx[c_px_w-1:0]);
    assign w_cy_lo = 8'(r_cy[c_py_w-1:0]);

    // Narrow counters have no bit 4; treat it as zero
    if (c_bits_x > 4) begin : g_cx4
        assign w_cx4 = r_cx[4];
    end else begin : g_cx4_zero
        assign w_cx4 = 1'b0;
    end

    if (c_bits_y > 4) begin : g_cy4
        assign w_cy4 = r_cy[4];
    end else begin : g_cy4_zero
        assign w_cy4 = 1'b0;
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else if (clk_pixel_ena) begin
            if (w_blank) begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end else begin
                r_r <= w_cx_lo;
                r_g <= w_cy_lo;
                r_b <= {8{w_cx4 ^ w_cy4}};
            end
        end
    end

    assign o_r = r_r;
    assign o_g = r_g;
    assign o_b = r_b;
`endif

endmodule
`default_nettype wire
